// File: rtl/sfp_link_sequencer.sv
// sfp_link_sequencer: per-channel SFP PCS/PMA reset sequencing, link wait with timeouts,
// bounded retries, all-fail global reset pulse and board status LEDs.
module sfp_link_sequencer #(
  parameter int SFP_COUNT         = 2,
  parameter int RESET_CYCLES      = 100,
  parameter int RESETDONE_TIMEOUT = 100000,
  parameter int LINK_TIMEOUT      = 1000000,
  parameter int LINK_DEBOUNCE     = 1000,
  parameter int MAX_RETRIES       = 7,
  parameter int BLINK_DIV         = 25000000
) (
  input  logic                   sysclk_100m,
  input  logic                   sys_reset_n,
  input  logic                   enable,
  input  logic [SFP_COUNT-1:0]   pcs_resetdone,
  input  logic [SFP_COUNT-1:0]   pcs_link_up,
  output logic [SFP_COUNT-1:0]   pcs_reset,
  output logic [SFP_COUNT-1:0]   link_ok,
  output logic [SFP_COUNT-1:0]   link_fail,
  output logic [4*SFP_COUNT-1:0] retry_count,
  output logic                   user_reset_out,
  output logic [3:0]             sleds
);
  localparam int CW = $clog2(LINK_TIMEOUT + 1);
  localparam int DW = $clog2(LINK_DEBOUNCE + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam int BW = $clog2(BLINK_DIV + 1);
  typedef enum logic [2:0] {IDLE, RST, WAIT_DONE, WAIT_LINK, UP, RETRY, FAIL} state_t;
  logic [SFP_COUNT-1:0] r_rd_m, r_rd_s, r_lu_m, r_lu_s, w_fail_st, w_busy;
  logic [4:0]           r_ur_cnt;
  logic                 r_all_fail_q, r_hb, w_start;
  logic [BW-1:0]        r_hb_cnt;
  always_ff @(posedge sysclk_100m or negedge sys_reset_n)
    if (!sys_reset_n) begin
      r_rd_m <= '0;
      r_rd_s <= '0;
      r_lu_m <= '0;
      r_lu_s <= '0;
    end else begin
      r_rd_m <= pcs_resetdone;
      r_rd_s <= r_rd_m;
      r_lu_m <= pcs_link_up;
      r_lu_s <= r_lu_m;
    end
  for (genvar c = 0; c < SFP_COUNT; c++) begin : g_ch
    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [DW-1:0] r_deb, w_deb;
    logic [RW-1:0] r_retries, w_retries;
    logic          r_pcs_reset, r_ok, r_fail, r_busy;
    logic [3:0]    r_rc;
    always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt + CW'(1);
      w_deb     = r_lu_s[c] ? r_deb + DW'(1) : '0;
      w_retries = r_retries;
      case (r_state)
        IDLE: begin
          w_retries = '0;
          w_cnt     = '0;
          if (enable) w_state = RST;
        end
        RST:
          if (r_cnt == CW'(RESET_CYCLES - 1)) begin
            w_state = WAIT_DONE;
            w_cnt   = '0;
          end
        WAIT_DONE:
          if (r_rd_s[c]) begin
            w_state = WAIT_LINK;
            w_cnt   = '0;
            w_deb   = '0;
          end else if (r_cnt == CW'(RESETDONE_TIMEOUT - 1)) w_state = RETRY;
        WAIT_LINK:
          if (!r_rd_s[c]) w_state = RETRY;
          else if (w_deb == DW'(LINK_DEBOUNCE)) begin
            w_state   = UP;
            w_retries = '0;
          end else if (r_cnt == CW'(LINK_TIMEOUT - 1)) w_state = RETRY;
        UP:
          if (!r_lu_s[c] || !r_rd_s[c]) w_state = RETRY;
        RETRY: begin
          w_cnt = '0;
          if (r_retries == RW'(MAX_RETRIES)) w_state = FAIL;
          else begin
            w_retries = r_retries + RW'(1);
            w_state   = RST;
          end
        end
        FAIL: ;
        default: w_state = IDLE;
      endcase
      if (!enable) begin
        w_state   = IDLE;
        w_retries = '0;
      end
    end
    always_ff @(posedge sysclk_100m or negedge sys_reset_n)
      if (!sys_reset_n) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_deb       <= '0;
        r_retries   <= '0;
        r_pcs_reset <= 1'b1;
        r_ok        <= 1'b0;
        r_fail      <= 1'b0;
        r_busy      <= 1'b0;
        r_rc        <= '0;
      end else begin
        r_state     <= w_state;
        r_cnt       <= w_cnt;
        r_deb       <= w_deb;
        r_retries   <= w_retries;
        r_pcs_reset <= r_state inside {IDLE, RST, FAIL};
        r_ok        <= r_state == UP;
        r_fail      <= r_state == FAIL;
        r_busy      <= r_state inside {RST, WAIT_DONE, WAIT_LINK, RETRY};
        r_rc        <= int'(r_retries) > 15 ? 4'd15 : 4'(r_retries);
      end
    assign pcs_reset[c]         = r_pcs_reset;
    assign link_ok[c]           = r_ok;
    assign link_fail[c]         = r_fail;
    assign retry_count[4*c +: 4] = r_rc;
    assign w_fail_st[c]         = r_state == FAIL;
    assign w_busy[c]            = r_busy;
  end
  // The pulse fires on the cycle all channels first sit in FAIL; leaving FAIL re-arms it.
  assign w_start = &w_fail_st && !r_all_fail_q;
  always_ff @(posedge sysclk_100m or negedge sys_reset_n)
    if (!sys_reset_n) begin
      r_all_fail_q <= 1'b0;
      r_ur_cnt     <= '0;
      r_hb_cnt     <= '0;
      r_hb         <= 1'b0;
    end else begin
      r_all_fail_q <= &w_fail_st;
      r_ur_cnt     <= w_start ? 5'd16 : (r_ur_cnt != 5'd0 ? r_ur_cnt - 5'd1 : 5'd0);
      r_hb_cnt     <= r_hb_cnt == BW'(BLINK_DIV - 1) ? '0 : r_hb_cnt + BW'(1);
      r_hb         <= r_hb_cnt == BW'(BLINK_DIV - 1) ? ~r_hb : r_hb;
    end
  assign user_reset_out = r_ur_cnt != 5'd0;
  assign sleds          = {|w_busy, |link_fail, &link_ok, r_hb};
endmodule

// File: tb/tb_sfp_link_sequencer.sv
// tb_sfp_link_sequencer: directed scenarios; expectations are queued with a target cycle
// and a negedge monitor compares the DUT outputs when that cycle arrives.
module tb_sfp_link_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, user_reset_out;
  logic [1:0] rd = 2'b00, lu = 2'b11, pcs_reset, link_ok, link_fail;
  logic [7:0] retry_count;
  logic [3:0] sleds;
  int         cyc = 0, checks = 0, errors = 0, ur_pulses = 0;
  logic       ur_prev = 1'b0;
  typedef struct {
    int         at;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;
  exp_t q[$];

  sfp_link_sequencer #(
    .SFP_COUNT(2), .RESET_CYCLES(4), .RESETDONE_TIMEOUT(20), .LINK_TIMEOUT(50),
    .LINK_DEBOUNCE(5), .MAX_RETRIES(2), .BLINK_DIV(8)
  ) dut (
    .sysclk_100m(clk), .sys_reset_n(rst_n), .enable(enable), .pcs_resetdone(rd),
    .pcs_link_up(lu), .pcs_reset(pcs_reset), .link_ok(link_ok), .link_fail(link_fail),
    .retry_count(retry_count), .user_reset_out(user_reset_out), .sleds(sleds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act(int sel);
    case (sel)
      0: return {6'd0, pcs_reset};
      1: return {6'd0, link_ok};
      2: return {6'd0, link_fail};
      3: return retry_count;
      4: return {7'd0, user_reset_out};
      5: return {5'd0, sleds[3:1]};
      6: return {7'd0, sleds[0]};
      default: return {4'd0, sleds};
    endcase
  endfunction

  task automatic check(string name, logic [7:0] a, logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, a, e, cyc);
    end
  endtask

  task automatic ex(int at, int sel, logic [7:0] v, string n);
    exp_t e;
    e.at = at;
    e.sel = sel;
    e.val = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic go(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (user_reset_out && !ur_prev) ur_pulses++;
    ur_prev = user_reset_out;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].at == cyc) begin
        check(q[i].name, act(q[i].sel), q[i].val);
        q.delete(i);
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c, e, f, g, h;
    ex(1, 0, 8'h3, "rst_pcs_reset");
    ex(1, 7, 8'h0, "rst_sleds");
    ex(2, 1, 8'h0, "rst_link_ok");
    ex(2, 2, 8'h0, "rst_link_fail");
    ex(2, 3, 8'h0, "rst_retry_count");
    ex(2, 4, 8'h0, "rst_user_reset");
    #22 rst_n = 1'b1;
    ex(cyc + 7, 6, 8'h0, "hb_before_toggle");
    ex(cyc + 8, 6, 8'h1, "hb_first_toggle");
    ex(cyc + 15, 6, 8'h1, "hb_hold");
    ex(cyc + 16, 6, 8'h0, "hb_second_toggle");
    @(posedge clk);
    #1;
    // normal bring-up; channel 1 sees reset-done two clocks after channel 0
    b = cyc;
    enable = 1'b1;
    ex(b + 1, 5, 8'h0, "s1_idle_leds");
    ex(b + 2, 5, 8'h4, "s1_busy_led");
    ex(b + 5, 0, 8'h3, "s1_pcs_reset_last");
    ex(b + 6, 0, 8'h0, "s1_pcs_reset_fall");
    ex(b + 17, 1, 8'h0, "s1_ok_before_debounce");
    ex(b + 18, 1, 8'h1, "s1_ok_ch0");
    ex(b + 19, 5, 8'h4, "s1_leds_one_up");
    ex(b + 20, 1, 8'h3, "s1_ok_both");
    ex(b + 20, 5, 8'h1, "s1_leds_all_up");
    ex(b + 20, 3, 8'h00, "s1_retry_zero");
    go(b + 9);
    rd[0] = 1'b1;
    go(b + 11);
    rd[1] = 1'b1;
    // link loss while UP, then a one-clock glitch during the new debounce
    ex(b + 25, 1, 8'h3, "s3_ok_before_loss");
    ex(b + 26, 1, 8'h2, "s3_ok_falls");
    ex(b + 26, 3, 8'h00, "s3_retry_before");
    ex(b + 27, 3, 8'h01, "s3_retry_one");
    ex(b + 26, 0, 8'h0, "s3_pcs_in_retry");
    ex(b + 27, 0, 8'h1, "s3_pcs_rst_start");
    ex(b + 30, 0, 8'h1, "s3_pcs_rst_end");
    ex(b + 31, 0, 8'h0, "s3_pcs_rst_fall");
    ex(b + 37, 1, 8'h2, "s3_glitch_restarts");
    ex(b + 39, 1, 8'h2, "s3_ok_not_yet");
    ex(b + 40, 1, 8'h3, "s3_ok_after_clean");
    ex(b + 40, 3, 8'h00, "s3_retry_cleared_up");
    go(b + 22);
    lu[0] = 1'b0;
    go(b + 26);
    lu[0] = 1'b1;
    go(b + 31);
    lu[0] = 1'b0;
    go(b + 32);
    lu[0] = 1'b1;
    // enable drop to IDLE, then reset-done timeouts on both channels
    c = b + 45;
    go(c);
    enable = 1'b0;
    rd = 2'b00;
    ex(c + 1, 1, 8'h3, "s2_ok_before_idle");
    ex(c + 2, 1, 8'h0, "s2_idle_ok");
    ex(c + 2, 0, 8'h3, "s2_idle_pcs");
    e = c + 3;
    go(e);
    enable = 1'b1;
    ex(e + 26, 0, 8'h0, "s2_pcs_retry_low");
    ex(e + 27, 0, 8'h3, "s2_pcs_rst_first");
    ex(e + 30, 0, 8'h3, "s2_pcs_rst_fourth");
    ex(e + 31, 0, 8'h0, "s2_pcs_rst_fall");
    ex(e + 28, 3, 8'h11, "s2_retry_one");
    ex(e + 76, 2, 8'h0, "s2_fail_not_yet");
    ex(e + 76, 5, 8'h4, "s2_leds_retry");
    ex(e + 77, 2, 8'h3, "s2_link_fail");
    ex(e + 77, 0, 8'h3, "s2_fail_pcs");
    ex(e + 77, 5, 8'h2, "s2_leds_fail");
    ex(e + 77, 3, 8'h22, "s2_retry_two");
    ex(e + 76, 4, 8'h0, "s4_ur_before");
    ex(e + 77, 4, 8'h1, "s4_ur_start");
    ex(e + 92, 4, 8'h1, "s4_ur_last");
    ex(e + 93, 4, 8'h0, "s4_ur_end");
    ex(e + 120, 4, 8'h0, "s4_ur_quiet");
    ex(e + 129, 2, 8'h3, "s2_fail_held");
    go(e + 125);
    check("s4_one_pulse", 8'(ur_pulses), 8'd1);
    // enable toggle re-arms the global reset pulse
    f = e + 130;
    go(f);
    enable = 1'b0;
    ex(f + 2, 2, 8'h0, "s4_fail_cleared");
    go(f + 3);
    enable = 1'b1;
    ex(f + 79, 4, 8'h0, "s4b_ur_before");
    ex(f + 80, 4, 8'h1, "s4b_ur_start");
    ex(f + 95, 4, 8'h1, "s4b_ur_last");
    ex(f + 96, 4, 8'h0, "s4b_ur_end");
    go(f + 105);
    check("s4b_two_pulses", 8'(ur_pulses), 8'd2);
    // channel 0 link timeout, then enable drop in WAIT_LINK, then async reset
    g = f + 110;
    go(g);
    enable = 1'b0;
    rd = 2'b11;
    lu = 2'b10;
    h = g + 3;
    go(h);
    enable = 1'b1;
    ex(h + 11, 1, 8'h0, "s5_ch1_not_up");
    ex(h + 12, 1, 8'h2, "s5_ch1_up");
    ex(h + 57, 0, 8'h0, "s5_link_timeout_retry");
    ex(h + 58, 0, 8'h1, "s5_link_timeout_rst");
    ex(h + 58, 3, 8'h01, "s5_retry_one");
    ex(h + 66, 0, 8'h0, "s5_pcs_before_idle");
    ex(h + 66, 3, 8'h01, "s5_retry_before_idle");
    ex(h + 66, 1, 8'h2, "s5_ok_before_idle");
    ex(h + 67, 0, 8'h3, "s5_idle_pcs");
    ex(h + 67, 3, 8'h00, "s5_idle_retry");
    ex(h + 67, 1, 8'h0, "s5_idle_ok");
    go(h + 65);
    enable = 1'b0;
    go(h + 70);
    enable = 1'b1;
    go(h + 78);
    check("s5_pre_reset_pcs", {6'd0, pcs_reset}, 8'h0);
    check("s5_pre_reset_busy", {7'd0, sleds[3]}, 8'h1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_pcs", {6'd0, pcs_reset}, 8'h3);
    check("s5_async_sleds", {4'd0, sleds}, 8'h0);
    check("s5_async_ok_fail", {4'd0, link_ok, link_fail}, 8'h0);
    check("s5_async_retry", retry_count, 8'h00);
    check("s5_async_ur", {7'd0, user_reset_out}, 8'h0);
    #13 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s not sampled (due cycle %0d)", q[i].name, q[i].at);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfp_link_sequencer.md
Name: sfp_link_sequencer

Overview:
- Per-channel bring-up and recovery controller for the SFP PCS/PMA cores, clocked on sysclk_100m.
- For each channel it:
  - sequences the core reset;
  - waits for the GT reset-done and link-up status, with timeouts;
  - retries with a bounded retry count.
- Also drives the four board status LEDs, and requests a global user reset when every channel has failed.
- Sits between the system controller and the per-SFP PCS/PMA instances inside the SFP test top.

Parameters:
- SFP_COUNT, 2, number of SFP channels.
- RESET_CYCLES, 100, length of the pcs_reset assertion in clocks (1 us).
- RESETDONE_TIMEOUT, 100000, maximum clocks to wait for reset-done (1 ms).
- LINK_TIMEOUT, 1000000, maximum clocks to wait for a stable link (10 ms).
- LINK_DEBOUNCE, 1000, consecutive clocks link_up must stay high before it is declared up.
- MAX_RETRIES, 7, failed attempts allowed before the channel enters FAIL.
- BLINK_DIV, 25000000, heartbeat half-period in clocks.

Ports:
- sysclk_100m  in  1  system clock, 100 MHz.
- sys_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; low forces all channels to IDLE.
- pcs_resetdone  in  SFP_COUNT  per-channel GT/PCS reset-done; asynchronous.
- pcs_link_up  in  SFP_COUNT  per-channel PCS link status; asynchronous.
- pcs_reset  out  SFP_COUNT  per-channel core reset, active-high.
- link_ok  out  SFP_COUNT  channel is in UP.
- link_fail  out  SFP_COUNT  channel is in FAIL.
- retry_count  out  4*SFP_COUNT  per-channel retries since the last UP, saturating at 15.
- user_reset_out  out  1  global reset request pulse to the system controller.
- sleds  out  4  status LEDs.

Behaviour:
- Reset (sys_reset_n low, asynchronous):
  - All channels go to IDLE, all counters clear.
  - pcs_reset is all ones.
  - link_ok, link_fail, retry_count, user_reset_out and sleds are all 0.
- Input synchronisation: pcs_resetdone and pcs_link_up pass through 2-flop synchronisers (rd_s, lu_s). Synchroniser flops reset to 0. Input-to-FSM latency is 2 clocks.
- Each channel runs an independent FSM with one cycle counter cnt (width $clog2(LINK_TIMEOUT+1)) and one debounce counter.
- IDLE:
  - pcs_reset=1, retry counter cleared.
  - If enable=1 -> RST with cnt=0.
- RST:
  - pcs_reset=1 for exactly RESET_CYCLES clocks.
  - When cnt==RESET_CYCLES-1 -> WAIT_DONE with cnt=0.
- WAIT_DONE:
  - pcs_reset=0.
  - rd_s=1 -> WAIT_LINK with cnt=0 and debounce=0.
  - Otherwise, cnt==RESETDONE_TIMEOUT-1 -> RETRY.
- WAIT_LINK:
  - Debounce counts while lu_s=1 and clears when lu_s=0.
  - Debounce reaches LINK_DEBOUNCE -> UP.
  - rd_s=0 -> RETRY.
  - cnt==LINK_TIMEOUT-1 -> RETRY.
  - If debounce completion and timeout land on the same cycle, UP wins.
- UP:
  - link_ok=1; the retry counter clears on entry.
  - lu_s=0 or rd_s=0 -> RETRY. There is no debounce on loss.
- RETRY (1 clock):
  - If retries==MAX_RETRIES -> FAIL.
  - Otherwise retries+1 -> RST with cnt=0.
- FAIL:
  - pcs_reset=1, link_fail=1.
  - Held until enable=0.
- enable=0 in any state -> IDLE on the next clock. This takes priority over all other transitions.
- Outputs are registered from state: they appear one clock after the state is entered.
- retry_count: the per-channel retry counter, saturated at 15 when MAX_RETRIES>15.
- user_reset_out:
  - When all channels are in FAIL, one 16-clock high pulse is generated.
  - The pulse re-arms only after at least one channel leaves FAIL.
  - An external sys_reset_n assertion during the pulse clears it immediately.
- sleds:
  - [0] heartbeat; toggles every BLINK_DIV clocks while out of reset.
  - [1] AND of link_ok.
  - [2] OR of link_fail.
  - [3] OR of channels in RST, WAIT_DONE, WAIT_LINK or RETRY.
- Reset mid-operation: asynchronous return to the reset values listed above. Sequencing restarts from IDLE.

Test Plan:
All scenarios use RESET_CYCLES=4, RESETDONE_TIMEOUT=20, LINK_TIMEOUT=50, LINK_DEBOUNCE=5, MAX_RETRIES=2, BLINK_DIV=8, SFP_COUNT=2.
1. Normal bring-up:
   - Stimulus: enable=1; rd raised 3 clocks after pcs_reset falls; lu held high.
   - Required: pcs_reset high exactly 4 clocks; link_ok[0]=1 after 5 debounce clocks plus sync latency; sleds[1]=1 once both channels are up; retry_count=0.
2. Reset-done timeout:
   - Stimulus: rd held 0.
   - Required: after 3 attempts (retries 0->1->2), link_fail=1; pcs_reset=1; sleds[2]=1; retry_count=2.
3. Link glitch:
   - Stimulus: lu pulses low for 1 clock in the middle of debounce.
   - Required: debounce restarts; UP is reached only after 5 clean clocks.
   - Stimulus: later, lu drops while UP.
   - Required: RETRY, then RST; link_ok falls 1 clock after the state change; retry_count=1.
4. All-fail global reset:
   - Stimulus: both channels time out.
   - Required: user_reset_out high for exactly 16 clocks, once only.
   - Stimulus: toggle enable 0->1 and let both channels fail again.
   - Required: the pulse re-arms and fires again.
5. Enable drop and async reset mid-WAIT_LINK:
   - Stimulus: enable=0.
   - Required: IDLE next clock; pcs_reset=1; retries cleared.
   - Stimulus: sys_reset_n low for a non-clock-aligned interval.
   - Required: outputs go to reset values immediately, without waiting for a clock edge; sleds=0.
6. Heartbeat:
   - Stimulus: free-running clock out of reset.
   - Required: sleds[0] toggles every 8 clocks from reset release, independent of enable.
